// File: rtl/signed_arith_pkg.sv
// Signed-arithmetic helpers shared by the adder/subtractor datapaths:
// overflow detection from sign bits and width-parameterized saturation limits.
package signed_arith_pkg;

    // sum - b overflows only when the operands differ in sign and the result sign departs from sum's.
    function automatic logic sub_ovf(input logic sum_msb, input logic b_msb, input logic d_msb);
        return (sum_msb != b_msb) && (d_msb != sum_msb);
    endfunction

    virtual class sat_lim #(parameter int N = 8);
        static function logic [N-1:0] sat_val(input logic neg);
            return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        endfunction
    endclass

endpackage

// File: rtl/hs_pipe_reg.sv
// Valid/ready register slice, 1 cycle latency, full throughput.
// Accepts when empty or when the held word drains this cycle; output holds while stalled.
module hs_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_dat
);
    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic         ld;

    assign in_ready  = !vld_q || out_ready;
    assign ld        = in_valid && in_ready;
    assign out_valid = vld_q;
    assign out_dat   = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ld) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/signed_sub_pipe.sv
// Pipelined signed subtractor a = sum - b with overflow flag, optional saturation and event counter.
// 2 cycles latency, 1/cycle throughput; out_ready stalls both stages and combinationally gates in_ready.
module signed_sub_pipe
    import signed_arith_pkg::*;
#(
    parameter int N        = 8,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sum,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     a,
    output logic             ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);
    logic             s1_valid, s1_ready;
    logic [2*N-1:0]   s1_dat;
    logic [N-1:0]     s1_sum, s1_b;
    logic [N-1:0]     diff, res;
    logic             res_ovf;
    logic [N:0]       s2_dat;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hs_pipe_reg #(.W(2*N)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    ({sum, b}),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_dat   (s1_dat)
    );

    assign s1_sum = s1_dat[2*N-1:N];
    assign s1_b   = s1_dat[N-1:0];

    // Only the low N bits of the sign-extended difference are ever observed; the flag needs just its MSB.
    assign diff    = s1_sum - s1_b;
    assign res_ovf = sub_ovf(s1_sum[N-1], s1_b[N-1], diff[N-1]);
    assign res     = (SATURATE && res_ovf) ? sat_lim#(N)::sat_val(s1_sum[N-1]) : diff;

    hs_pipe_reg #(.W(N+1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_dat    ({res_ovf, res}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (s2_dat)
    );

    assign ovf     = s2_dat[N];
    assign a       = s2_dat[N-1:0];
    assign ovf_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && ovf && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_signed_sub_pipe.sv
// Bench: wrap, saturate and 2-bit-counter instances share stimulus and are checked every cycle
// against a queue-based reference of the subtractor, plus literal expectations from hand-worked cases.
module tb_signed_sub_pipe;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, clr_cnt;
    logic [N-1:0] sum, b;

    logic         in_ready_w, out_valid_w, ovf_w;
    logic [N-1:0] a_w;
    logic [7:0]   cnt_w;
    logic         in_ready_s, out_valid_s, ovf_s;
    logic [N-1:0] a_s;
    logic [7:0]   cnt_s;
    logic         in_ready_c, out_valid_c, ovf_c;
    logic [N-1:0] a_c;
    logic [1:0]   cnt_c;

    always #5 clk = ~clk;

    signed_sub_pipe #(.N(N), .SATURATE(1'b0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .sum(sum), .b(b),
        .out_valid(out_valid_w), .out_ready(out_ready), .a(a_w), .ovf(ovf_w),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_w));

    signed_sub_pipe #(.N(N), .SATURATE(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .sum(sum), .b(b),
        .out_valid(out_valid_s), .out_ready(out_ready), .a(a_s), .ovf(ovf_s),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_s));

    signed_sub_pipe #(.N(N), .SATURATE(1'b0), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .sum(sum), .b(b),
        .out_valid(out_valid_c), .out_ready(out_ready), .a(a_c), .ovf(ovf_c),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_c));

    typedef struct {
        int sv;
        int bv;
        int ent;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    m_cnt8 = 0, m_cnt2 = 0;
    int    errors = 0, checks = 0;
    bit    chk_en = 1'b0;
    bit    m_vld, m_rdy, m_ovf;
    int    m_d, m_aw, m_as;
    item_t it;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference: items in flight in order; the oldest is visible one edge after it entered.
    always @(negedge clk) begin
        m_vld = (q.size() > 0) && (q[0].ent < cyc);
        m_rdy = (q.size() < 2) || out_ready;
        m_ovf = 1'b0;
        m_aw  = 0;
        m_as  = 0;
        if (m_vld) begin
            m_d   = q[0].sv - q[0].bv;
            m_ovf = (m_d > 127) || (m_d < -128);
            m_aw  = (m_d > 127) ? m_d - 256 : (m_d < -128) ? m_d + 256 : m_d;
            m_as  = (m_d > 127) ? 127 : (m_d < -128) ? -128 : m_d;
        end
        if (chk_en) begin
            chk("in_ready_wrap", in_ready_w, m_rdy);
            chk("in_ready_sat", in_ready_s, m_rdy);
            chk("in_ready_cnt2", in_ready_c, m_rdy);
            chk("out_valid_wrap", out_valid_w, m_vld);
            chk("out_valid_sat", out_valid_s, m_vld);
            chk("out_valid_cnt2", out_valid_c, m_vld);
            if (m_vld) begin
                chk("a_wrap", $signed(a_w), m_aw);
                chk("a_sat", $signed(a_s), m_as);
                chk("a_cnt2", $signed(a_c), m_aw);
                chk("ovf_wrap", ovf_w, m_ovf);
                chk("ovf_sat", ovf_s, m_ovf);
                chk("ovf_cnt2", ovf_c, m_ovf);
            end
            chk("ovf_cnt_wrap", cnt_w, m_cnt8);
            chk("ovf_cnt_sat", cnt_s, m_cnt8);
            chk("ovf_cnt_cnt2", cnt_c, m_cnt2);
        end
        if (rst) begin
            q.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            if (m_vld && out_ready) begin
                void'(q.pop_front());
                if (m_ovf) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
            if (clr_cnt) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end
            if (in_valid && m_rdy) begin
                it.sv  = $signed(sum);
                it.bv  = $signed(b);
                it.ent = cyc + 1;
                q.push_back(it);
            end
        end
    end

    function automatic logic [N-1:0] pick();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0:       return 8'h80;
                1:       return 8'h7F;
                2:       return 8'hFF;
                3:       return 8'h00;
                default: return 8'h01;
            endcase
        end
        return N'($urandom);
    endfunction

    // One isolated pair; result must appear exactly two cycles after the handshake cycle.
    task automatic pin(input int s, input int bb, input int ew, input int es, input bit eo);
        @(posedge clk); #1;
        in_valid = 1'b1; sum = N'(s); b = N'(bb); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pin_not_yet_valid", out_valid_w, 1'b0);
        @(negedge clk);
        chk("pin_valid", out_valid_w, 1'b1);
        chk("pin_a_wrap", $signed(a_w), ew);
        chk("pin_a_sat", $signed(a_s), es);
        chk("pin_ovf", ovf_w, eo);
    endtask

    int got[$];
    int acc;
    bit hs_in;
    int exp_seq[3] = '{10, 20, 30};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; sum = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid_w, 1'b0);
        chk("rst_a", $signed(a_w), 0);
        chk("rst_ovf", ovf_w, 1'b0);
        chk("rst_cnt", cnt_w, 0);
        chk("rst_in_ready", in_ready_w, 1'b1);

        pin(2, 1, 1, 1, 1'b0);
        pin(0, 1, -1, -1, 1'b0);
        pin(127, -1, -128, 127, 1'b1);
        pin(-128, 1, 127, -128, 1'b1);
        @(negedge clk);
        chk("cnt_after_two_ovf", cnt_w, 2);
        pin(0, -128, -128, 127, 1'b1);
        pin(5, 5, 0, 0, 1'b0);
        pin(-3, -3, 0, 0, 1'b0);

        // Backpressure: consumer stalled for 4 cycles while 10,20,30 are offered.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; sum = 8'd10; b = '0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hs_in = in_valid && in_ready_w;
            if (hs_in) acc++;
            @(posedge clk); #1;
            if (hs_in) sum = sum + 8'd10;
        end
        @(negedge clk);
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", in_ready_w, 1'b0);
        chk("bp_a_held", $signed(a_w), 10);
        @(posedge clk); #1;
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            @(negedge clk);
            if (out_valid_w && out_ready) got.push_back(int'($signed(a_w)));
            hs_in = in_valid && in_ready_w;
            @(posedge clk); #1;
            if (hs_in) begin
                if (sum == 8'd30) in_valid = 1'b0;
                else sum = sum + 8'd10;
            end
        end
        chk("bp_out_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", (got.size() > i) ? got[i] : -1, exp_seq[i]);

        // Reset with both stages holding data.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; sum = 8'd50; b = '0;
        @(posedge clk); #1 sum = 8'd60;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", out_valid_w, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid_w, 1'b0);
        chk("midrst_cnt", cnt_w, 0);
        chk("midrst_in_ready", in_ready_w, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid_w, 1'b0);
        end

        // Five back-to-back overflows saturate the 2-bit counter.
        @(posedge clk); #1;
        in_valid = 1'b1; sum = 8'd127; b = 8'hFF;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("cnt2_sticks", cnt_c, 3);
        chk("cnt8_five", cnt_w, 5);

        // Clear lands on the same edge as an overflowing output handshake.
        @(posedge clk); #1;
        in_valid = 1'b1; sum = 8'h80; b = 8'h01;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_item_present", out_valid_w, 1'b1);
        @(posedge clk); #1 clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_priority_wrap", cnt_w, 0);
        chk("clr_priority_cnt2", cnt_c, 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            sum       = pick();
            b         = pick();
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drained", out_valid_w, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_sub_pipe.md
Name: signed_sub_pipe

Overview:
Pipelined signed subtractor, the inverse of the signed adder. Given a sum and one addend b, it recovers the other addend a = sum - b. It has valid/ready handshakes on both sides, overflow detection, optional saturation and a saturating overflow-event counter. It sits downstream of the adder datapath and is used for operand recovery and adder self-checking.

Parameters:
N, 8, operand/result width in bits (signed two's complement), N >= 2
SATURATE, 0, 1 = clamp result on overflow; 0 = two's-complement wrap
CNT_W, 8, width of overflow event counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  sum/b pair valid
in_ready  output  1  block can accept pair this cycle
sum  input  N  signed minuend
b  input  N  signed subtrahend
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
a  output  N  signed result sum - b (wrapped or saturated)
ovf  output  1  true signed overflow occurred for this result (qualified by out_valid)
clr_cnt  input  1  synchronous clear of ovf_cnt
ovf_cnt  output  CNT_W  count of delivered results with ovf=1, saturates at all-ones

Behaviour:
- Reset (rst=1 at clk edge): s1_valid=0, s2_valid=0, out_valid=0, a=0, ovf=0, ovf_cnt=0. Reset mid-operation discards all in-flight data. in_ready=1 in the first cycle after reset.
- Two register stages. S1 captures sum and b. S2 captures the computed result and ovf. out_valid = s2_valid.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput: 1 per cycle.
- Advance rules:
  - s2_ld = s1_valid && (!s2_valid || out_ready)
  - s1_ld = in_valid && in_ready
  - in_ready = !s1_valid || s2_ld
  - The combinational path out_ready -> in_ready is permitted.
- S1 update:
  - if s1_ld: load sum and b, set s1_valid=1
  - else if s2_ld: clear s1_valid
- S2 update:
  - if s2_ld: load result, set s2_valid=1
  - else if out_ready: clear s2_valid
- Output hold: a and ovf hold stable while out_valid && !out_ready. No data loss and no duplication. Order is preserved.
- Arithmetic:
  - Compute d = sum - b at N+1 bits with sign extension.
  - ovf = (sum[N-1] != b[N-1]) && (d[N-1] != sum[N-1]).
  - SATURATE=0: a = d[N-1:0].
  - SATURATE=1 with ovf: a = 2^(N-1)-1 if sum is non-negative, else -2^(N-1).
  - ovf is reported in both modes.
- Counter:
  - Increments by 1 on each output handshake (out_valid && out_ready) with ovf=1.
  - Holds at 2^CNT_W-1.
  - clr_cnt sets it to 0 and has priority over a simultaneous increment.
- Edge cases:
  - b = -2^(N-1) with sum >= 0 always overflows.
  - sum = b gives a = 0, ovf = 0.
  - in_valid=0: s1 may drain while s2 is stalled.

Decomposition:
- Package signed_arith_pkg:
  - function sub_ovf(sum, b, d) returning the overflow bit
  - function sat_val(neg) returning the N-bit max/min; parameterized via a let or a class-static parameterization
- One sub-module, hs_pipe_reg: a width-parameterized valid/ready register slice. It is instantiated twice, and the combinational subtract sits between the instances.

Test Plan:
- N=8, SATURATE=0: sum=2,b=1 -> a=1, ovf=0, out_valid 2 cycles after the handshake. sum=0,b=1 -> a=8'hFF (-1), ovf=0.
- Overflow wrap: sum=127,b=-1 -> a=-128, ovf=1. sum=-128,b=1 -> a=127, ovf=1. ovf_cnt=2 after both are accepted.
- SATURATE=1: sum=127,b=-1 -> a=127, ovf=1. sum=-128,b=1 -> a=-128, ovf=1. sum=0,b=-128 -> a=127, ovf=1.
- Backpressure: stream sums 10,20,30 with b=0 and out_ready=0 for 4 cycles.
  - Exactly 2 pairs are accepted, then in_ready=0.
  - a holds at 10.
  - On release, outputs are 10,20,30 in order, none dropped or duplicated.
- Reset mid-operation: assert rst with both stages full -> next cycle out_valid=0, ovf_cnt=0, in_ready=1, and the stale data never appears.
- Counter: CNT_W=2, 5 consecutive overflowing results -> ovf_cnt sticks at 3. clr_cnt coincident with an overflow handshake -> ovf_cnt=0.
